// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback unit: widths, load funct3 codes, FSM states.
package writeback_unit_pkg;

  localparam int DATAW_DEF = 32;
  localparam int ADDRW_DEF = 5;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_t;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Bus bundle between the pipeline (master) and the writeback unit (slave).
// Handshakes: a transfer happens on a rising clock edge where both valid
// and ready are 1; a producer holds its payload stable while valid && !ready.
interface writeback_unit_if
  import writeback_unit_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int ADDRW = ADDRW_DEF
) ();

  logic             alu_valid;
  logic             alu_ready;
  logic [ADDRW-1:0] alu_rd;
  logic [DATAW-1:0] alu_data;

  logic             ld_issue_valid;
  logic             ld_issue_ready;
  logic [ADDRW-1:0] ld_rd;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_offset;

  logic             mem_rvalid;
  logic [DATAW-1:0] mem_rdata;

  logic             rf_write_enable;
  logic [ADDRW-1:0] rf_addr_rd;
  logic [DATAW-1:0] rf_data_rd;

  logic             load_busy;
  logic [ADDRW-1:0] load_pending_rd;

  logic             fwd_valid;
  logic [ADDRW-1:0] fwd_addr;
  logic [DATAW-1:0] fwd_data;

  logic             err_misaligned;
  logic             err_timeout;
  logic             err_unexpected;

  state_t           dbg_state;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue_valid, ld_rd, ld_funct3, ld_offset,
    output mem_rvalid, mem_rdata,
    input  alu_ready, ld_issue_ready,
    input  rf_write_enable, rf_addr_rd, rf_data_rd,
    input  load_busy, load_pending_rd,
    input  fwd_valid, fwd_addr, fwd_data,
    input  err_misaligned, err_timeout, err_unexpected,
    input  dbg_state
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue_valid, ld_rd, ld_funct3, ld_offset,
    input  mem_rvalid, mem_rdata,
    output alu_ready, ld_issue_ready,
    output rf_write_enable, rf_addr_rd, rf_data_rd,
    output load_busy, load_pending_rd,
    output fwd_valid, fwd_addr, fwd_data,
    output err_misaligned, err_timeout, err_unexpected,
    output dbg_state
  );

endinterface

// File: rtl/writeback_unit_load_formatter.sv
// Combinational load data extraction and alignment check for one memory word.
module writeback_unit_load_formatter
  import writeback_unit_pkg::*;
#(
  parameter int DATAW = DATAW_DEF
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       offset,
  input  logic [DATAW-1:0] rdata,
  output logic [DATAW-1:0] data,
  output logic             misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half and extend it according to the load type.
  always_comb begin
    byte_sel   = rdata[{offset, 3'b000} +: 8];
    half_sel   = rdata[{offset[1], 4'b0000} +: 16];
    data       = '0;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{(DATAW-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(DATAW-8){1'b0}}, byte_sel};
      F3_LH: begin
        data       = {{(DATAW-16){half_sel[15]}}, half_sel};
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = {{(DATAW-16){1'b0}}, half_sel};
        misaligned = offset[0];
      end
      F3_LW: begin
        data       = rdata;
        misaligned = (offset != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback: arbitrates ALU results against load responses,
// tracks one outstanding load with a timeout, and forwards each write.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DATAW       = DATAW_DEF,
  parameter int ADDRW       = ADDRW_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input logic            clock,
  input logic            reset_n,
  writeback_unit_if.slave bus
);

  localparam int              CNTW     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [CNTW-1:0]  counter;
  logic [ADDRW-1:0] cap_rd;
  logic [2:0]       cap_funct3;
  logic [1:0]       cap_offset;

  logic             rf_we_q;
  logic [ADDRW-1:0] rf_addr_q;
  logic [DATAW-1:0] rf_data_q;
  logic             fwd_valid_q;
  logic [ADDRW-1:0] fwd_addr_q;
  logic [DATAW-1:0] fwd_data_q;
  logic             err_mis_q;
  logic             err_to_q;
  logic             err_unx_q;

  logic [2:0]       fmt_funct3;
  logic [1:0]       fmt_offset;
  logic [DATAW-1:0] fmt_data;
  logic             fmt_misaligned;
  logic             load_resp;
  logic             alu_accept;

  // In IDLE the formatter checks alignment of the load being issued;
  // in WAIT_MEM it formats the response using the captured attributes.
  assign fmt_funct3 = (state == S_IDLE) ? bus.ld_funct3 : cap_funct3;
  assign fmt_offset = (state == S_IDLE) ? bus.ld_offset : cap_offset;

  writeback_unit_load_formatter #(.DATAW(DATAW)) u_fmt (
    .funct3     (fmt_funct3),
    .offset     (fmt_offset),
    .rdata      (bus.mem_rdata),
    .data       (fmt_data),
    .misaligned (fmt_misaligned)
  );

  assign load_resp  = (state == S_WAIT_MEM) && bus.mem_rvalid;
  assign alu_accept = bus.alu_valid && !load_resp;

  // FSM, timeout counter, write/forward registers and sticky errors.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      counter     <= '0;
      cap_rd      <= '0;
      cap_funct3  <= '0;
      cap_offset  <= '0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      err_mis_q   <= 1'b0;
      err_to_q    <= 1'b0;
      err_unx_q   <= 1'b0;
    end else begin
      rf_we_q     <= 1'b0;
      fwd_valid_q <= rf_we_q;
      fwd_addr_q  <= rf_addr_q;
      fwd_data_q  <= rf_data_q;

      // A load response blocks the ALU this cycle, so these never collide.
      if (alu_accept && (bus.alu_rd != '0)) begin
        rf_we_q   <= 1'b1;
        rf_addr_q <= bus.alu_rd;
        rf_data_q <= bus.alu_data;
      end

      case (state)
        S_IDLE: begin
          if (bus.mem_rvalid) err_unx_q <= 1'b1;
          if (bus.ld_issue_valid) begin
            if (fmt_misaligned) begin
              err_mis_q <= 1'b1;
            end else begin
              state      <= S_WAIT_MEM;
              counter    <= '0;
              cap_rd     <= bus.ld_rd;
              cap_funct3 <= bus.ld_funct3;
              cap_offset <= bus.ld_offset;
            end
          end
        end
        S_WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            state  <= S_IDLE;
            cap_rd <= '0;
            if (cap_rd != '0) begin
              rf_we_q   <= 1'b1;
              rf_addr_q <= cap_rd;
              rf_data_q <= fmt_data;
            end
          end else if (counter == CNT_LAST) begin
            err_to_q <= 1'b1;
            state    <= S_IDLE;
            cap_rd   <= '0;
          end else begin
            counter <= counter + CNTW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_ready       = !load_resp;
  assign bus.ld_issue_ready  = (state == S_IDLE);
  assign bus.load_busy       = (state == S_WAIT_MEM);
  assign bus.load_pending_rd = cap_rd;
  assign bus.rf_write_enable = rf_we_q;
  assign bus.rf_addr_rd      = rf_addr_q;
  assign bus.rf_data_rd      = rf_data_q;
  assign bus.fwd_valid       = fwd_valid_q;
  assign bus.fwd_addr        = fwd_addr_q;
  assign bus.fwd_data        = fwd_data_q;
  assign bus.err_misaligned  = err_mis_q;
  assign bus.err_timeout     = err_to_q;
  assign bus.err_unexpected  = err_unx_q;
  assign bus.dbg_state       = state;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU path, load formatting, arbitration,
// x0 suppression, misalignment, unexpected response, timeout and reset.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  writeback_unit_if bus ();

  writeback_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and reset defaults
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past one rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid      = 1'b0;
    bus.alu_rd         = '0;
    bus.alu_data       = '0;
    bus.ld_issue_valid = 1'b0;
    bus.ld_rd          = '0;
    bus.ld_funct3      = '0;
    bus.ld_offset      = '0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  // Issue a load, wait one cycle in WAIT_MEM, then present the response.
  // Returns with the response edge passed, so rf_* show the load result.
  task automatic load_txn(input logic [2:0] f3, input logic [1:0] off,
                          input logic [4:0] rd, input logic [31:0] rdata);
    bus.ld_issue_valid = 1'b1;
    bus.ld_funct3      = f3;
    bus.ld_offset      = off;
    bus.ld_rd          = rd;
    tick();
    bus.ld_issue_valid = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    tick();
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_rf_we",    32'(bus.rf_write_enable), 32'd0);
    check("rst_rf_data",  bus.rf_data_rd, 32'd0);
    check("rst_fwd",      32'(bus.fwd_valid), 32'd0);
    check("rst_busy",     32'(bus.load_busy), 32'd0);
    check("rst_pend",     32'(bus.load_pending_rd), 32'd0);
    check("rst_issue_rdy", 32'(bus.ld_issue_ready), 32'd1);
    check("rst_alu_rdy",  32'(bus.alu_ready), 32'd1);
    check("rst_errs", {29'd0, bus.err_misaligned, bus.err_timeout, bus.err_unexpected}, 32'd0);
    reset_n = 1'b1;
    tick();

    // ALU write to x5, then forwarding copy
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    #1;
    check("alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    check("alu_we",   32'(bus.rf_write_enable), 32'd1);
    check("alu_addr", 32'(bus.rf_addr_rd), 32'd5);
    check("alu_data", bus.rf_data_rd, 32'hDEADBEEF);
    tick();
    check("alu_we_pulse", 32'(bus.rf_write_enable), 32'd0);
    check("fwd_valid", 32'(bus.fwd_valid), 32'd1);
    check("fwd_addr",  32'(bus.fwd_addr), 32'd5);
    check("fwd_data",  bus.fwd_data, 32'hDEADBEEF);
    tick();
    check("fwd_valid_off", 32'(bus.fwd_valid), 32'd0);

    // LB rd=3 off=2, with busy/pending checks while waiting
    bus.ld_issue_valid = 1'b1;
    bus.ld_funct3      = F3_LB;
    bus.ld_offset      = 2'd2;
    bus.ld_rd          = 5'd3;
    tick();
    bus.ld_issue_valid = 1'b0;
    check("lb_busy",      32'(bus.load_busy), 32'd1);
    check("lb_pend",      32'(bus.load_pending_rd), 32'd3);
    check("lb_issue_rdy", 32'(bus.ld_issue_ready), 32'd0);
    check("lb_state",     32'(bus.dbg_state), 32'(S_WAIT_MEM));
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00800000;
    #1;
    check("lb_alu_blocked", 32'(bus.alu_ready), 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
    check("lb_we",   32'(bus.rf_write_enable), 32'd1);
    check("lb_addr", 32'(bus.rf_addr_rd), 32'd3);
    check("lb_data", bus.rf_data_rd, 32'hFFFFFF80);
    check("lb_idle", 32'(bus.load_busy), 32'd0);
    check("lb_pend_clr", 32'(bus.load_pending_rd), 32'd0);

    // Other load formats
    load_txn(F3_LBU, 2'd2, 5'd3, 32'h00800000);
    check("lbu_data", bus.rf_data_rd, 32'h00000080);
    load_txn(F3_LB, 2'd3, 5'd8, 32'h7F000000);
    check("lb3_data", bus.rf_data_rd, 32'h0000007F);
    load_txn(F3_LH, 2'd2, 5'd7, 32'h80011234);
    check("lh_data", bus.rf_data_rd, 32'hFFFF8001);
    load_txn(F3_LHU, 2'd0, 5'd7, 32'h8001F234);
    check("lhu_data", bus.rf_data_rd, 32'h0000F234);
    check("lhu_addr", 32'(bus.rf_addr_rd), 32'd7);

    // LW response collides with an ALU result: load first, ALU next
    bus.ld_issue_valid = 1'b1;
    bus.ld_funct3      = F3_LW;
    bus.ld_offset      = 2'd0;
    bus.ld_rd          = 5'd10;
    tick();
    bus.ld_issue_valid = 1'b0;
    bus.mem_rvalid     = 1'b1;
    bus.mem_rdata      = 32'h12345678;
    bus.alu_valid      = 1'b1;
    bus.alu_rd         = 5'd9;
    bus.alu_data       = 32'hCAFEF00D;
    #1;
    check("col_alu_rdy0", 32'(bus.alu_ready), 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
    check("col_ld_addr", 32'(bus.rf_addr_rd), 32'd10);
    check("col_ld_data", bus.rf_data_rd, 32'h12345678);
    check("col_alu_rdy1", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    check("col_alu_we",   32'(bus.rf_write_enable), 32'd1);
    check("col_alu_addr", 32'(bus.rf_addr_rd), 32'd9);
    check("col_alu_data", bus.rf_data_rd, 32'hCAFEF00D);
    check("col_fwd_addr", 32'(bus.fwd_addr), 32'd10);
    tick();

    // ALU write to x0 is accepted but suppressed
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'h55555555;
    #1;
    check("x0_alu_rdy", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    check("x0_alu_we", 32'(bus.rf_write_enable), 32'd0);

    // Load to x0 completes without a write
    load_txn(F3_LW, 2'd0, 5'd0, 32'hAAAAAAAA);
    check("x0_ld_we",   32'(bus.rf_write_enable), 32'd0);
    check("x0_ld_busy", 32'(bus.load_busy), 32'd0);

    // Misaligned LH off=1
    bus.ld_issue_valid = 1'b1;
    bus.ld_funct3      = F3_LH;
    bus.ld_offset      = 2'd1;
    bus.ld_rd          = 5'd4;
    tick();
    bus.ld_issue_valid = 1'b0;
    check("mis_err",  32'(bus.err_misaligned), 32'd1);
    check("mis_rdy",  32'(bus.ld_issue_ready), 32'd1);
    check("mis_busy", 32'(bus.load_busy), 32'd0);
    check("mis_we",   32'(bus.rf_write_enable), 32'd0);
    check("mis_no_unx", 32'(bus.err_unexpected), 32'd0);

    // Response while idle
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h11111111;
    tick();
    bus.mem_rvalid = 1'b0;
    check("unx_err", 32'(bus.err_unexpected), 32'd1);
    check("unx_we",  32'(bus.rf_write_enable), 32'd0);
    check("unx_no_to", 32'(bus.err_timeout), 32'd0);

    // Load that never answers
    bus.ld_issue_valid = 1'b1;
    bus.ld_funct3      = F3_LW;
    bus.ld_offset      = 2'd0;
    bus.ld_rd          = 5'd4;
    tick();
    bus.ld_issue_valid = 1'b0;
    for (int i = 0; i < 250; i++) tick();
    check("to_still_busy", 32'(bus.load_busy), 32'd1);
    check("to_not_yet",    32'(bus.err_timeout), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("to_err",  32'(bus.err_timeout), 32'd1);
    check("to_busy", 32'(bus.load_busy), 32'd0);
    check("to_rdy",  32'(bus.ld_issue_ready), 32'd1);
    check("to_we",   32'(bus.rf_write_enable), 32'd0);
    check("mis_sticky", 32'(bus.err_misaligned), 32'd1);

    // Reset in the middle of a load drops it
    bus.ld_issue_valid = 1'b1;
    bus.ld_rd          = 5'd6;
    tick();
    bus.ld_issue_valid = 1'b0;
    tick();
    check("mid_busy", 32'(bus.load_busy), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_busy", 32'(bus.load_busy), 32'd0);
    check("mid_rst_pend", 32'(bus.load_pending_rd), 32'd0);
    check("mid_rst_we",   32'(bus.rf_write_enable), 32'd0);
    check("mid_rst_fwd",  32'(bus.fwd_valid), 32'd0);
    check("mid_rst_errs", {29'd0, bus.err_misaligned, bus.err_timeout, bus.err_unexpected}, 32'd0);
    check("mid_rst_rdy",  32'(bus.ld_issue_ready), 32'd1);
    reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_we",   32'(bus.rf_write_enable), 32'd0);
    check("post_rst_busy", 32'(bus.load_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
